dmem_bus_ctrl: RTL and testbench
================================

# dmem_bus_ctrl

Sequential bus master between the load/store alignment stage and the data memory/peripheral bus. Takes the word-aligned address, shifted write data and byte mask from the alignment stage and runs a single valid/ready bus transaction. Stalls the core while the transaction is in progress, then returns registered read data to the alignment stage for extraction and sign extension. Bus errors and a per-access timeout are reported as a fault.

## Interface
- TIMEOUT_CYCLES, 255: maximum BUSY cycles without a handshake before fault; 0 disables the timeout; legal range 0..65535.
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_read  in  1  load request; held by the core while stall=1.
- req_write  in  1  store request; held by the core while stall=1.
- req_addr  in  32  word-aligned address; bits [1:0] are 0.
- req_wdata  in  32  lane-shifted store data.
- req_wmask  in  4  byte-lane write mask.
- stall  out  1  holds the core pipeline.
- done  out  1  one-cycle pulse at access completion.
- fault  out  1  one-cycle pulse coincident with done on bus error or timeout.
- load_data  out  32  registered read word sent to the alignment stage.
- bus_valid  out  1  request valid.
- bus_we  out  1  1 = write.
- bus_addr  out  32  request address.
- bus_wdata  out  32  write data.
- bus_wstrb  out  4  byte strobes; 0000 for reads.
- bus_ready  in  1  slave accepts/completes the access.
- bus_rdata  in  32  read data; valid when bus_ready=1.
- bus_err  in  1  slave error; sampled only when bus_ready=1.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if req_write or req_read, latch addr/wdata/wmask/we into bus registers, clear the timeout counter, and go to BUSY. If both requests are high, the write is performed and the read is ignored.
- BUSY: bus_valid=1 and the bus outputs are stable. A handshake occurs when bus_valid and bus_ready are both 1. On handshake: capture bus_rdata into load_data (reads only; stores leave load_data unchanged), set the fault flag if bus_err=1, and go to DONE. On a read with bus_err=1, load_data=0.
- Timeout: the counter increments each BUSY cycle without a handshake. When it reaches TIMEOUT_CYCLES-1 without a handshake, set fault, force load_data=0 for reads, and go to DONE. A handshake in that same cycle takes priority and is not a fault.
- DONE: done=1, fault=latched flag, stall=0. Unconditional transition to IDLE.
- stall = (IDLE and (req_read or req_write)) or BUSY. stall is combinational from the request inputs and state.
- The core must change or drop its request in the cycle after done. A request still present in IDLE starts a new access.
- Reset values: state=IDLE, bus_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wstrb=0, load_data=0, done=0, fault=0, counter=0. stall is 0 while no request is present.

## Timing
- Zero-wait access: request seen in cycle T0 (stall=1); bus_valid=1 in T1; bus_ready=1 in T1; done=1 and load_data valid in T2. This gives a 3-cycle access with 2 stall cycles.
- With N wait cycles (bus_ready low), done arrives at T2+N.
- bus_valid must not drop and bus outputs must not change in BUSY until the handshake or timeout.
- bus_valid is low in DONE, so there is no back-to-back transfer. The minimum spacing between accesses is 3 cycles.
- Reset mid-BUSY: bus_valid=0 after the reset edge and the transaction is abandoned. No done or fault is issued.

## Structure
- Package dmem_bus_pkg holds:
  - the state enum IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - the TIMEOUT counter width constant, 16.
- Sub-module bus_timeout_ctr: a 16-bit counter with clear, enable and an expire output compared against TIMEOUT_CYCLES. Tied off when TIMEOUT_CYCLES=0.

## Test plan
- Zero-wait load: req_read=1, req_addr=0x0000_0104, and the slave returns ready with rdata=0xDEAD_BEEF in T1. Expected: bus_we=0, bus_wstrb=0000, done=1 in T2, load_data=0xDEAD_BEEF, fault=0.
- Store with 3 wait cycles: req_write=1, addr=0x0000_0200, wdata=0x0000_AB00, wmask=0010. Expected: bus outputs stable for 4 cycles, done in T5, load_data unchanged.
- Bus error: a read is acknowledged with bus_err=1. Expected: done=fault=1 in the same cycle, load_data=0.
- Timeout: TIMEOUT_CYCLES=4 and bus_ready held at 0. Expected: bus_valid=1 for exactly 4 cycles, then done=fault=1, then IDLE.
- Simultaneous req_read=req_write=1: expected bus_we=1 and a single transaction.
- Reset asserted in the 2nd wait cycle: expected bus_valid=0, stall=0 and done=0 after the edge. A following zero-wait load completes normally.

Source files
------------

// File: rtl/dmem_bus_ctrl_pkg.sv
// dmem_bus_pkg: shared types and constants for the data-memory bus master.
//   state_t    - access sequencer states (IDLE, BUSY, DONE)
//   TMO_CTR_W  - width of the per-access timeout counter
package dmem_bus_pkg;

  localparam int unsigned TMO_CTR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_bus_ctrl_if.sv
// dmem_bus_ctrl_if: single-beat valid/ready data bus.
//   bus_valid/bus_we/bus_addr/bus_wdata/bus_wstrb : master -> slave request
//   bus_ready/bus_rdata/bus_err                    : slave -> master response
//   modport master : used by dmem_bus_ctrl
//   modport slave  : used by a memory/peripheral model
interface dmem_bus_ctrl_if;

  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ready, bus_rdata, bus_err
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ready, bus_rdata, bus_err
  );

endinterface

// File: rtl/dmem_bus_ctrl_timeout.sv
// bus_timeout_ctr: per-access wait counter for dmem_bus_ctrl.
//   clk, reset : clock, synchronous active-high reset
//   i_clear    : zero the counter (held while no access is in flight)
//   i_en       : count one cycle without a handshake
//   o_expire   : counter has reached TIMEOUT_CYCLES-1
// TIMEOUT_CYCLES = 0 removes the counter and never expires.
module bus_timeout_ctr
  import dmem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign o_expire = 1'b0;
    end else begin : g_on
      localparam logic [TMO_CTR_W-1:0] LIMIT = TMO_CTR_W'(TIMEOUT_CYCLES - 32'd1);

      logic [TMO_CTR_W-1:0] r_count;

      always_ff @(posedge clk) begin
        if (reset || i_clear) begin
          r_count <= '0;
        end else if (i_en) begin
          r_count <= r_count + 1'b1;
        end
      end

      // The sequencer leaves BUSY on expiry, so the count never passes LIMIT.
      assign o_expire = (r_count == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/dmem_bus_ctrl.sv
// dmem_bus_ctrl: sequential bus master between the load/store alignment
// stage and the data memory/peripheral bus. One valid/ready transaction per
// request; the core is stalled until it completes.
//   clk, reset              : clock, synchronous active-high reset
//   req_read, req_write     : load/store request, held while stall=1
//   req_addr/wdata/wmask    : word address, lane-shifted data, byte mask
//   stall                   : hold the core pipeline (combinational)
//   done                    : one-cycle completion pulse
//   fault                   : with done, bus error or timeout
//   load_data               : registered read word
//   bus                     : master side of dmem_bus_ctrl_if
module dmem_bus_ctrl
  import dmem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_read,
  input  logic                   req_write,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  input  logic [3:0]             req_wmask,
  output logic                   stall,
  output logic                   done,
  output logic                   fault,
  output logic [31:0]            load_data,
  dmem_bus_ctrl_if.master        bus
);

  state_t      r_state;
  logic        r_bus_valid;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_wstrb;
  logic [31:0] r_load_data;
  logic        r_done;
  logic        r_fault;

  logic        w_req;
  logic        w_busy;
  logic        w_handshake;
  logic        w_expire;

  assign w_req       = req_read | req_write;
  assign w_busy      = (r_state == BUSY);
  assign w_handshake = w_busy & r_bus_valid & bus.bus_ready;

  bus_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (!w_busy),
    .i_en     (w_busy & !w_handshake),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bus_valid <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wstrb <= '0;
      r_load_data <= '0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            // A store wins when both requests are raised together.
            r_bus_valid <= 1'b1;
            r_bus_we    <= req_write;
            r_bus_addr  <= req_addr;
            r_bus_wdata <= req_wdata;
            r_bus_wstrb <= req_write ? req_wmask : 4'b0000;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          // Handshake is checked first so a same-cycle expiry is not a fault.
          if (w_handshake) begin
            r_bus_valid <= 1'b0;
            r_done      <= 1'b1;
            r_fault     <= bus.bus_err;
            if (!r_bus_we) begin
              r_load_data <= bus.bus_err ? '0 : bus.bus_rdata;
            end
            r_state <= DONE;
          end else if (w_expire) begin
            r_bus_valid <= 1'b0;
            r_done      <= 1'b1;
            r_fault     <= 1'b1;
            if (!r_bus_we) begin
              r_load_data <= '0;
            end
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_bus_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign stall         = ((r_state == IDLE) & w_req) | w_busy;
  assign done          = r_done;
  assign fault         = r_fault;
  assign load_data     = r_load_data;

  assign bus.bus_valid = r_bus_valid;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_wdata = r_bus_wdata;
  assign bus.bus_wstrb = r_bus_wstrb;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Self-checking bench for dmem_bus_ctrl: directed scenarios plus randomized
// accesses against a transaction-level model (per-access cycle windows).
module tb_dmem_bus_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wmask = '0;
  logic        stall;
  logic        done;
  logic        fault;
  logic [31:0] load_data;

  dmem_bus_ctrl_if u_bus();

  dmem_bus_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_read  (req_read),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .stall     (stall),
    .done      (done),
    .fault     (fault),
    .load_data (load_data),
    .bus       (u_bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Model of the current access: stall over [m_t0, m_d-1], bus_valid over
  // [m_t0+1, m_d-1], done/fault at m_d, load_data m_old before m_d, m_new after.
  int          m_t0 = 0;
  int          m_d = 0;
  bit          m_we = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_wstrb = '0;
  bit          m_fault = 1'b0;
  logic [31:0] m_old = '0;
  logic [31:0] m_new = '0;

  // Slave behaviour for the current access.
  int          s_nwait = 0;
  bit          s_err = 1'b0;
  logic [31:0] s_rdata = '0;
  int          s_wcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  initial begin
    u_bus.bus_ready = 1'b0;
    u_bus.bus_rdata = '0;
    u_bus.bus_err   = 1'b0;
  end

  // Slave: ready after s_nwait valid cycles; garbage on rdata/err otherwise.
  always @(posedge clk) begin
    #1;
    if (u_bus.bus_valid === 1'b1) begin
      if (s_wcnt == s_nwait) begin
        u_bus.bus_ready = 1'b1;
        u_bus.bus_rdata = s_rdata;
        u_bus.bus_err   = s_err;
      end else begin
        u_bus.bus_ready = 1'b0;
        u_bus.bus_rdata = $urandom;
        u_bus.bus_err   = 1'($urandom_range(0, 1));
      end
      s_wcnt++;
    end else begin
      u_bus.bus_ready = 1'b0;
      u_bus.bus_rdata = $urandom;
      u_bus.bus_err   = 1'b0;
      s_wcnt = 0;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    int c;
    bit busy_w;
    bit stall_w;
    logic [31:0] ld;
    if (chk_en) begin
      c       = cyc;
      busy_w  = (c > m_t0) && (c < m_d);
      stall_w = (c >= m_t0) && (c < m_d);
      ld      = (c >= m_d) ? m_new : m_old;
      chk("stall", 32'(stall), 32'(stall_w));
      chk("bus_valid", 32'(u_bus.bus_valid), 32'(busy_w));
      chk("done", 32'(done), 32'(c == m_d));
      chk("fault", 32'(fault), 32'((c == m_d) && m_fault));
      chk("load_data", load_data, ld);
      if (busy_w) begin
        chk("bus_we", 32'(u_bus.bus_we), 32'(m_we));
        chk("bus_addr", u_bus.bus_addr, m_addr);
        chk("bus_wdata", u_bus.bus_wdata, m_wdata);
        chk("bus_wstrb", 32'(u_bus.bus_wstrb), 32'(m_wstrb));
      end
    end
  end

  // Called at posedge+1 of an IDLE cycle: raise the request and predict it.
  task automatic start_access(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] mask,
                              input int nwait, input bit err, input logic [31:0] rdata);
    logic [31:0] cur;
    cur       = (cyc >= m_d) ? m_new : m_old;
    req_read  = rd;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = mask;
    s_nwait   = nwait;
    s_err     = err;
    s_rdata   = rdata;
    m_t0      = cyc;
    m_we      = wr;
    m_addr    = addr;
    m_wdata   = wdata;
    m_wstrb   = wr ? mask : 4'b0000;
    m_old     = cur;
    if (TO != 0 && nwait >= int'(TO)) begin
      m_d     = cyc + 1 + int'(TO);
      m_fault = 1'b1;
      m_new   = wr ? cur : 32'h0;
    end else begin
      m_d     = cyc + 2 + nwait;
      m_fault = err;
      m_new   = wr ? cur : (err ? 32'h0 : rdata);
    end
  endtask

  // Hold the request through done, drop it in the following cycle.
  task automatic finish_access();
    while (cyc < m_d + 1) begin
      @(posedge clk);
      #1;
    end
    req_read  = 1'b0;
    req_write = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wmask = 4'($urandom);
  endtask

  task automatic at_neg(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    bit rd, wr;

    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    at_neg(cyc);
    chk("rst_bus_valid", 32'(u_bus.bus_valid), 32'h0);
    chk("rst_bus_addr", u_bus.bus_addr, 32'h0);
    chk("rst_bus_wstrb", 32'(u_bus.bus_wstrb), 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    next_cycle();

    // Zero-wait load
    t0 = cyc;
    start_access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'hF, 0, 1'b0, 32'hDEAD_BEEF);
    at_neg(t0);
    chk("zw_stall_t0", 32'(stall), 32'h1);
    at_neg(t0 + 1);
    chk("zw_valid_t1", 32'(u_bus.bus_valid), 32'h1);
    chk("zw_we_t1", 32'(u_bus.bus_we), 32'h0);
    chk("zw_wstrb_t1", 32'(u_bus.bus_wstrb), 32'h0);
    chk("zw_addr_t1", u_bus.bus_addr, 32'h0000_0104);
    at_neg(t0 + 2);
    chk("zw_done_t2", 32'(done), 32'h1);
    chk("zw_fault_t2", 32'(fault), 32'h0);
    chk("zw_load_t2", load_data, 32'hDEAD_BEEF);
    finish_access();

    // Store, 3 wait cycles (handshake lands on the cycle the timeout would expire)
    t0 = cyc;
    start_access(1'b0, 1'b1, 32'h0000_0200, 32'h0000_AB00, 4'b0010, 3, 1'b0, 32'h7777_7777);
    at_neg(t0 + 4);
    chk("st_valid_t4", 32'(u_bus.bus_valid), 32'h1);
    chk("st_wstrb_t4", 32'(u_bus.bus_wstrb), 32'h2);
    chk("st_wdata_t4", u_bus.bus_wdata, 32'h0000_AB00);
    at_neg(t0 + 5);
    chk("st_done_t5", 32'(done), 32'h1);
    chk("st_fault_t5", 32'(fault), 32'h0);
    chk("st_load_t5", load_data, 32'hDEAD_BEEF);
    finish_access();

    // Read acknowledged with bus error
    t0 = cyc;
    start_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1, 1'b1, 32'h1234_5678);
    at_neg(t0 + 3);
    chk("err_done", 32'(done), 32'h1);
    chk("err_fault", 32'(fault), 32'h1);
    chk("err_load", load_data, 32'h0);
    finish_access();

    // Nonzero load so the timeout's zeroing is visible
    start_access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, 1'b0, 32'hCAFE_F00D);
    finish_access();

    // Timeout: slave never answers
    t0 = cyc;
    start_access(1'b1, 1'b0, 32'h0000_0030, 32'h0, 4'h0, 50, 1'b0, 32'h0);
    at_neg(t0 + 4);
    chk("to_valid_t4", 32'(u_bus.bus_valid), 32'h1);
    at_neg(t0 + 5);
    chk("to_valid_t5", 32'(u_bus.bus_valid), 32'h0);
    chk("to_done", 32'(done), 32'h1);
    chk("to_fault", 32'(fault), 32'h1);
    chk("to_load", load_data, 32'h0);
    finish_access();
    at_neg(cyc);
    chk("to_idle_done", 32'(done), 32'h0);
    chk("to_idle_stall", 32'(stall), 32'h0);
    next_cycle();

    start_access(1'b1, 1'b0, 32'h0000_0024, 32'h0, 4'h0, 0, 1'b0, 32'hCAFE_F00D);
    finish_access();

    // Simultaneous read and write: one store transaction
    t0 = cyc;
    start_access(1'b1, 1'b1, 32'h0000_0040, 32'h1122_3344, 4'hF, 0, 1'b0, 32'h5555_5555);
    at_neg(t0 + 1);
    chk("both_we", 32'(u_bus.bus_we), 32'h1);
    chk("both_wstrb", 32'(u_bus.bus_wstrb), 32'hF);
    at_neg(t0 + 2);
    chk("both_load", load_data, 32'hCAFE_F00D);
    finish_access();
    at_neg(cyc);
    chk("both_single", 32'(u_bus.bus_valid), 32'h0);
    next_cycle();

    // Reset in the 2nd wait cycle
    t0 = cyc;
    start_access(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 3, 1'b0, 32'hAAAA_5555);
    at_neg(t0 + 2);
    chk("rb_valid_pre", 32'(u_bus.bus_valid), 32'h1);
    #1;
    reset    = 1'b1;
    req_read = 1'b0;
    next_cycle();
    reset   = 1'b0;
    m_t0    = 0;
    m_d     = 0;
    m_fault = 1'b0;
    m_old   = '0;
    m_new   = '0;
    at_neg(cyc);
    chk("rb_valid", 32'(u_bus.bus_valid), 32'h0);
    chk("rb_stall", 32'(stall), 32'h0);
    chk("rb_done", 32'(done), 32'h0);
    chk("rb_load", load_data, 32'h0);
    next_cycle();
    t0 = cyc;
    start_access(1'b1, 1'b0, 32'h0000_0304, 32'h0, 4'h0, 0, 1'b0, 32'h0BAD_F00D);
    at_neg(t0 + 2);
    chk("rb_after_done", 32'(done), 32'h1);
    chk("rb_after_load", load_data, 32'h0BAD_F00D);
    finish_access();

    // Randomized accesses
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    begin rd = 1'b1; wr = 1'b0; end
        2, 3:    begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
      start_access(rd, wr, {$urandom, 2'b00} & 32'hFFFF_FFFC, $urandom, 4'($urandom),
                   int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0), $urandom);
      finish_access();
      repeat ($urandom_range(0, 2)) next_cycle();
    end

    repeat (2) next_cycle();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
